n_bit_alu: RTL and testbench

Parameterised, registered N-bit integer ALU. Applies one of eight operations selected by a 3-bit control code to two N-bit operands. Produces an N-bit result and a zero flag, both registered on the clock. Used as the datapath execute stage, between operand selection and write-back.

---
 rtl/n_bit_alu.sv | 98 +++++++++
 tb/tb_n_bit_alu.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/n_bit_alu.sv
// Registered n-bit integer ALU: eight ops selected by a 3-bit control code, with a zero flag.
// Define ALU_FLAGS_EN to add the registered carry/no-borrow and signed-overflow flags.
module n_bit_alu #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [n-1:0] operand1,
    input  logic [n-1:0] operand2,
    input  logic [2:0]   control,
    output logic [n-1:0] result,
    output logic         zero
`ifdef ALU_FLAGS_EN
    ,
    output logic         carry,
    output logic         overflow
`endif
);

    localparam int SHW = $clog2(n);
    localparam logic [SHW:0] NLIM = (SHW+1)'(n);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOR = 3'b101,
        OP_SLT = 3'b110,
        OP_SLL = 3'b111
    } op_e;

    op_e            op;
    logic [SHW-1:0] shamt;
    logic [n-1:0]   r;

    assign op    = op_e'(control);
    assign shamt = operand2[SHW-1:0];

    always_comb begin
        r = '0;
        unique case (op)
            OP_ADD: r = operand1 + operand2;
            OP_SUB: r = operand1 - operand2;
            OP_AND: r = operand1 & operand2;
            OP_OR:  r = operand1 | operand2;
            OP_XOR: r = operand1 ^ operand2;
            OP_NOR: r = ~(operand1 | operand2);
            OP_SLT: r = {{(n-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
            // shamt can only reach n or beyond when n is not a power of two
            OP_SLL: r = ({1'b0, shamt} >= NLIM) ? '0 : (operand1 << shamt);
            default: r = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            zero   <= 1'b1;
        end else begin
            result <= r;
            zero   <= (r == '0);
        end
    end

`ifdef ALU_FLAGS_EN
    logic [n:0] sum, diff;
    logic       carry_nxt, ovf_nxt;

    assign sum  = {1'b0, operand1} + {1'b0, operand2};
    assign diff = {1'b0, operand1} - {1'b0, operand2};

    always_comb begin
        carry_nxt = 1'b0;
        ovf_nxt   = 1'b0;
        if (op == OP_ADD) begin
            carry_nxt = sum[n];
            ovf_nxt   = (operand1[n-1] == operand2[n-1]) && (sum[n-1] != operand1[n-1]);
        end else if (op == OP_SUB) begin
            // borrow out of the extended subtraction means A < B unsigned
            carry_nxt = ~diff[n];
            ovf_nxt   = (operand1[n-1] != operand2[n-1]) && (diff[n-1] != operand1[n-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            carry    <= carry_nxt;
            overflow <= ovf_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_n_bit_alu.sv
// Bench for n_bit_alu (n = 32): behavioural model plus per-cycle compare, literal spot checks, random stimulus.
module tb_n_bit_alu;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] operand1 = '0, operand2 = '0;
    logic [2:0]   control = '0;
    logic [N-1:0] result;
    logic         zero;
`ifdef ALU_FLAGS_EN
    logic         carry, overflow;
`endif

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    n_bit_alu #(.n(N)) dut (
        .clk(clk), .rst_n(rst_n), .operand1(operand1), .operand2(operand2),
        .control(control), .result(result), .zero(zero)
`ifdef ALU_FLAGS_EN
        , .carry(carry), .overflow(overflow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] r;
        logic         c;
        logic         v;
    } exp_t;

    // Reference computed from plain 64-bit integer arithmetic
    function automatic exp_t model(input logic [2:0] c, input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        longint unsigned ua, ub, us;
        longint sa, sb, ss;
        longint maxs, mins;
        int sh;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        maxs = (64'sd1 <<< (N-1)) - 1;
        mins = -(64'sd1 <<< (N-1));
        e = '0;
        case (c)
            3'd0: begin
                us = ua + ub;
                ss = sa + sb;
                e.r = us[N-1:0];
                e.c = (us >= (64'd1 << N));
                e.v = (ss > maxs) || (ss < mins);
            end
            3'd1: begin
                us = ua - ub;
                ss = sa - sb;
                e.r = us[N-1:0];
                e.c = (ua >= ub);
                e.v = (ss > maxs) || (ss < mins);
            end
            3'd2: e.r = a & b;
            3'd3: e.r = a | b;
            3'd4: e.r = a ^ b;
            3'd5: e.r = ~(a | b);
            3'd6: e.r = (sa < sb) ? N'(1) : N'(0);
            default: begin
                sh = int'(ub % longint'(N));
                e.r = (sh >= N) ? '0 : N'(ua << sh);
            end
        endcase
        return e;
    endfunction

    exp_t exp_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_q <= '0;
        else        exp_q <= model(control, operand1, operand2);
    end

    task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_result", result, exp_q.r);
            chk("cyc_zero", N'(zero), N'(exp_q.r == '0));
`ifdef ALU_FLAGS_EN
            chk("cyc_carry", N'(carry), N'(exp_q.c));
            chk("cyc_overflow", N'(overflow), N'(exp_q.v));
`endif
        end
    end

    // Drive inputs, let one edge capture them, then sample 1 time unit after the edge
    task automatic step(input logic [2:0] c, input logic [N-1:0] a, input logic [N-1:0] b);
        control = c; operand1 = a; operand2 = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        operand1 = $urandom; operand2 = $urandom; control = 3'($urandom);
        #1 rst_n = 1'b0;
        #2;
        chk("reset_result", result, '0);
        chk("reset_zero", N'(zero), N'(1));
`ifdef ALU_FLAGS_EN
        chk("reset_carry", N'(carry), '0);
        chk("reset_overflow", N'(overflow), '0);
`endif
        chk_en = 1'b1;
        control = 3'd0; operand1 = 32'd15; operand2 = 32'd12;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("sweep_add", result, 32'd27);
        step(3'd1, 32'd15, 32'd12); chk("sweep_sub", result, 32'd3);
        step(3'd2, 32'd15, 32'd12); chk("sweep_and", result, 32'd12);
        step(3'd3, 32'd15, 32'd12); chk("sweep_or", result, 32'd15);
        step(3'd4, 32'd15, 32'd12); chk("sweep_xor", result, 32'd3);
        step(3'd5, 32'd15, 32'd12); chk("sweep_nor", result, 32'hFFFF_FFF0);
        step(3'd6, 32'd15, 32'd12); chk("sweep_slt", result, 32'd0);
        chk("sweep_slt_zero", N'(zero), N'(1));
        step(3'd7, 32'd15, 32'd12); chk("sweep_sll", result, 32'h0000_F000);

        step(3'd1, 32'h1234, 32'h1234); chk("sub_eq", result, '0);
        chk("sub_eq_zero", N'(zero), N'(1));
        step(3'd0, 32'hFFFF_FFFF, 32'd1); chk("add_wrap", result, '0);
        chk("add_wrap_zero", N'(zero), N'(1));
`ifdef ALU_FLAGS_EN
        chk("add_wrap_carry", N'(carry), N'(1));
`endif
        step(3'd6, 32'h8000_0000, 32'd1); chk("slt_neg", result, 32'd1);
        step(3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF); chk("add_ovf", result, 32'hFFFF_FFFE);
`ifdef ALU_FLAGS_EN
        chk("add_ovf_flag", N'(overflow), N'(1));
`endif
        step(3'd1, 32'h8000_0000, 32'd1); chk("sub_ovf", result, 32'h7FFF_FFFF);
`ifdef ALU_FLAGS_EN
        chk("sub_ovf_flag", N'(overflow), N'(1));
        chk("sub_ovf_carry", N'(carry), N'(1));
`endif
        step(3'd7, 32'd1, 32'd31); chk("sll_31", result, 32'h8000_0000);
        step(3'd7, 32'd1, 32'd32); chk("sll_32", result, 32'd1);

        // Async reset between edges during back-to-back ADDs
        step(3'd0, 32'd100, 32'd23); chk("b2b_add1", result, 32'd123);
        control = 3'd0; operand1 = 32'd40; operand2 = 32'd2;
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_result", result, '0);
        chk("midrst_zero", N'(zero), N'(1));
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_add", result, 32'd42);

        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: b = 32'h7FFF_FFFF;
                2: b = a;
                3: b = $urandom_range(0, 63);
                default: ;
            endcase
            step(3'($urandom_range(0, 7)), a, b);
        end
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
